// File: rtl/instr_mem_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_boot_loader_pkg
// Description : Shared types and constants for the instruction memory boot
//               loader (FSM state encoding, run/hold counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_boot_loader_pkg;

    typedef enum logic [2:0] {
        BOOT_IDLE  = 3'd0,
        BOOT_HOLD  = 3'd1,
        BOOT_LOAD  = 3'd2,
        BOOT_CHECK = 3'd3,
        BOOT_RUN   = 3'd4,
        BOOT_DONE  = 3'd5,
        BOOT_ERR   = 3'd6
    } boot_state_e;

    localparam int RUN_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/instr_mem_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_boot_loader_if
// Description : Boot stream (valid/ready) plus instruction memory write port.
//               slave  : the boot loader (consumes the stream, drives memory)
//               master : the environment (boot source and memory side)
// Ports       : s_valid, s_data, s_ready, im_we, im_addr, im_wdata
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_boot_loader_if #(
    parameter int XLEN = 32,
    parameter int IN_W = 8,
    parameter int AW   = 5
);
    logic            s_valid;
    logic [IN_W-1:0] s_data;
    logic            s_ready;
    logic            im_we;
    logic [AW-1:0]   im_addr;
    logic [XLEN-1:0] im_wdata;

    modport master (
        output s_valid, s_data,
        input  s_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, im_we, im_addr, im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_boot_loader_packer.sv
`default_nettype none
// ============================================================================
// Module      : boot_word_packer
// Description : Assembles XLEN-bit words from IN_W-bit beats, little-endian
//               (first beat lands in the low bits).
// Ports       : clk, rst_n    - clock, async active-low reset
//               i_clear       - drop any partial word
//               i_beat_en     - a beat is transferred this cycle
//               i_beat_data   - beat payload
//               o_word_valid  - this beat completes a word
//               o_word        - completed word (valid with o_word_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module boot_word_packer #(
    parameter int XLEN = 32,
    parameter int IN_W = 8
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire             i_clear,
    input  wire             i_beat_en,
    input  wire  [IN_W-1:0] i_beat_data,
    output logic            o_word_valid,
    output logic [XLEN-1:0] o_word
);
    localparam int c_BEATS = XLEN / IN_W;
    localparam int c_CW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    logic [c_CW-1:0] r_beat_cnt;
    logic [XLEN-1:0] r_shift;
    logic [XLEN-1:0] w_shift_nxt;
    logic            w_last_beat;

    assign w_last_beat = (r_beat_cnt == c_CW'(c_BEATS - 1));

    // Shift right so that after BEATS beats the first one sits at bit 0.
    generate
        if (c_BEATS == 1) begin : g_single_beat
            assign w_shift_nxt = i_beat_data;
        end else begin : g_multi_beat
            assign w_shift_nxt = {i_beat_data, r_shift[XLEN-1:IN_W]};
        end
    endgenerate

    // The word is presented in the same cycle as its final beat so the
    // consumer can register the memory write on that very edge.
    assign o_word_valid = i_beat_en & w_last_beat;
    assign o_word       = w_shift_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_shift    <= '0;
        end else if (i_clear) begin
            r_beat_cnt <= '0;
            r_shift    <= '0;
        end else if (i_beat_en) begin
            r_shift    <= w_shift_nxt;
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + c_CW'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/instr_mem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_boot_loader
// Description : Holds the core in reset, streams INSTR_MEM_DEPTH words into
//               instruction memory, verifies a trailing XOR checksum word,
//               then releases the core for run_cycles cycles and flags done.
// Ports       : clk, rst_n            - clock, async active-low reset
//               start, skip_load      - begin sequence / bypass the load
//               run_cycles            - core run length before done
//               bus (slave)           - boot stream in, memory write out
//               core_rst_n            - core reset (active-low)
//               busy, done, error     - sequence status
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_boot_loader
    import instr_mem_boot_loader_pkg::*;
#(
    parameter int INSTR_MEM_DEPTH = 20,
    parameter int XLEN            = 32,
    parameter int IN_W            = 8,
    parameter int HOLD_CYCLES     = 5
) (
    input  wire                     clk,
    input  wire                     rst_n,
    input  wire                     start,
    input  wire                     skip_load,
    input  wire [RUN_CNT_W-1:0]     run_cycles,
    instr_mem_boot_loader_if.slave  bus,
    output logic                    core_rst_n,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int c_AW = (INSTR_MEM_DEPTH > 1) ? $clog2(INSTR_MEM_DEPTH) : 1;
    localparam logic [RUN_CNT_W-1:0] c_HOLD_LAST = RUN_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_AW-1:0]      c_LAST_IDX  = c_AW'(INSTR_MEM_DEPTH - 1);

    generate
        if ((XLEN % IN_W) != 0) begin : g_bad_width
            $error("instr_mem_boot_loader: XLEN must be a multiple of IN_W");
        end
        if (HOLD_CYCLES < 1) begin : g_bad_hold
            $error("instr_mem_boot_loader: HOLD_CYCLES must be at least 1");
        end
    endgenerate

    boot_state_e           r_state, w_state_nxt;
    logic [RUN_CNT_W-1:0]  r_cnt, r_run_cycles;
    logic                  r_skip;
    logic [c_AW-1:0]       r_idx;
    logic [XLEN-1:0]       r_csum;

    logic                  r_s_ready, r_im_we;
    logic [c_AW-1:0]       r_im_addr;
    logic [XLEN-1:0]       r_im_wdata;
    logic                  r_core_rst_n, r_busy, r_done, r_error;

    logic                  w_beat, w_word_valid, w_start_ok, w_run_last;
    logic [XLEN-1:0]       w_word;

    // Transfers are qualified by the registered ready, so nothing on the
    // stream inputs reaches an output without passing a flop.
    assign w_beat     = bus.s_valid & r_s_ready;
    assign w_start_ok = start & ((r_state == BOOT_IDLE) || (r_state == BOOT_DONE) ||
                                 (r_state == BOOT_ERR));
    // run_cycles == 0 still yields one RUN cycle.
    assign w_run_last = (r_run_cycles == '0) || (r_cnt == r_run_cycles - RUN_CNT_W'(1));

    boot_word_packer #(
        .XLEN (XLEN),
        .IN_W (IN_W)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_start_ok),
        .i_beat_en    (w_beat),
        .i_beat_data  (bus.s_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT_IDLE, BOOT_DONE, BOOT_ERR: if (start) w_state_nxt = BOOT_HOLD;
            BOOT_HOLD:  if (r_cnt == c_HOLD_LAST) w_state_nxt = r_skip ? BOOT_RUN : BOOT_LOAD;
            BOOT_LOAD:  if (w_word_valid && (r_idx == c_LAST_IDX)) w_state_nxt = BOOT_CHECK;
            // r_csum already includes the last loaded word at this point.
            BOOT_CHECK: if (w_word_valid) w_state_nxt = (w_word == r_csum) ? BOOT_RUN : BOOT_ERR;
            BOOT_RUN:   if (w_run_last) w_state_nxt = BOOT_DONE;
            default:    w_state_nxt = BOOT_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_run_cycles <= '0;
            r_skip       <= 1'b0;
            r_idx        <= '0;
            r_csum       <= '0;
            r_s_ready    <= 1'b0;
            r_im_we      <= 1'b0;
            r_im_addr    <= '0;
            r_im_wdata   <= '0;
            r_core_rst_n <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_s_ready    <= (w_state_nxt == BOOT_LOAD) || (w_state_nxt == BOOT_CHECK);
            r_core_rst_n <= (w_state_nxt == BOOT_RUN) || (w_state_nxt == BOOT_DONE);
            r_busy       <= (w_state_nxt == BOOT_HOLD) || (w_state_nxt == BOOT_LOAD) ||
                            (w_state_nxt == BOOT_CHECK) || (w_state_nxt == BOOT_RUN);
            r_done       <= (w_state_nxt == BOOT_DONE);
            r_error      <= (w_state_nxt == BOOT_ERR);

            // Shared hold/run counter restarts on every state change.
            if (r_state != w_state_nxt)
                r_cnt <= '0;
            else if ((r_state == BOOT_HOLD) || (r_state == BOOT_RUN))
                r_cnt <= r_cnt + RUN_CNT_W'(1);

            r_im_we <= 1'b0;
            if ((r_state == BOOT_LOAD) && w_word_valid) begin
                r_im_we    <= 1'b1;
                r_im_addr  <= r_idx;
                r_im_wdata <= w_word;
                r_csum     <= r_csum ^ w_word;
                r_idx      <= r_idx + c_AW'(1);
            end

            if (w_start_ok) begin
                r_skip       <= skip_load;
                r_run_cycles <= run_cycles;
                r_idx        <= '0;
                r_csum       <= '0;
            end
        end
    end

    assign bus.s_ready  = r_s_ready;
    assign bus.im_we    = r_im_we;
    assign bus.im_addr  = r_im_addr;
    assign bus.im_wdata = r_im_wdata;
    assign core_rst_n   = r_core_rst_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
endmodule
`default_nettype wire
